// File: rtl/line_column_feeder.sv
// Raster-to-column front end for the 3x3 median window: two line buffers produce
// the (y-2, y-1, y) column for every accepted pixel. Optional: LINE_COLUMN_FEEDER_ZERO_PAD_EN.
module line_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof_i,
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic                  pix_valid_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic [DATA_WIDTH-1:0] mid_o,
  output logic [DATA_WIDTH-1:0] bot_o,
  output logic                  col_valid_o,
  output logic [XW-1:0]         col_x_o,
  output logic [YW-1:0]         row_y_o,
  output logic                  frame_done_o
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] lb_a [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_b [IMG_WIDTH];

  logic [XW-1:0]         x_q, px;
  logic [YW-1:0]         y_q, py;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, top_n, mid_n;
  logic                  valid_n, x_last, y_last;

  // sof_i re-labels the current pixel as (0,0) in the same cycle
  assign px     = sof_i ? '0 : x_q;
  assign py     = sof_i ? '0 : y_q;
  assign rd_a   = lb_a[px];
  assign rd_b   = lb_b[px];
  assign x_last = (px == X_LAST);
  assign y_last = (py == Y_LAST);

`ifdef LINE_COLUMN_FEEDER_ZERO_PAD_EN
  always_comb begin
    top_n   = (py < YW'(2)) ? '0 : rd_a;
    mid_n   = (py == '0)    ? '0 : rd_b;
    valid_n = 1'b1;
  end
`else
  always_comb begin
    top_n   = rd_a;
    mid_n   = rd_b;
    valid_n = (py >= YW'(2));
  end
`endif

  // Nonblocking writes give read-before-write at the shared address
  always_ff @(posedge clk) begin
    if (pix_valid_i) begin
      lb_a[px] <= rd_b;
      lb_b[px] <= pix_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      top_o        <= '0;
      mid_o        <= '0;
      bot_o        <= '0;
      col_x_o      <= '0;
      row_y_o      <= '0;
      col_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      col_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      if (pix_valid_i) begin
        top_o        <= top_n;
        mid_o        <= mid_n;
        bot_o        <= pix_i;
        col_x_o      <= px;
        row_y_o      <= py;
        col_valid_o  <= valid_n;
        frame_done_o <= x_last && y_last;
        x_q          <= x_last ? '0 : px + XW'(1);
        if (x_last) y_q <= y_last ? '0 : py + YW'(1);
        else        y_q <= py;
      end else if (sof_i) begin
        x_q <= '0;
        y_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_line_column_feeder.sv
// Scoreboard bench for line_column_feeder on a 4x4 image with pixel = base + 16*y + x.
module tb_line_column_feeder;

`ifdef LINE_COLUMN_FEEDER_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sof_i = 1'b0;
  logic [7:0] pix_i = '0;
  logic       pix_valid_i = 1'b0;
  logic [7:0] top_o, mid_o, bot_o;
  logic       col_valid_o, frame_done_o;
  logic [1:0] col_x_o, row_y_o;

  line_column_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sof_i(sof_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .top_o(top_o), .mid_o(mid_o), .bot_o(bot_o), .col_valid_o(col_valid_o),
    .col_x_o(col_x_o), .row_y_o(row_y_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] top, mid, bot;
    logic [1:0] x, y;
    logic       done;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  int n_cols = 0, n_done = 0, n_done_exp = 0;
  int mx = 0, my = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (col_valid_o) begin
        exp_t e;
        n_cols++;
        chk("col_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("top", 32'(top_o), 32'(e.top));
          chk("mid", 32'(mid_o), 32'(e.mid));
          chk("bot", 32'(bot_o), 32'(e.bot));
          chk("col_x", 32'(col_x_o), 32'(e.x));
          chk("row_y", 32'(row_y_o), 32'(e.y));
          chk("frame_done", 32'(frame_done_o), 32'(e.done));
        end
        if (frame_done_o) n_done++;
      end else begin
        chk("done_idle", 32'(frame_done_o), 32'd0);
      end
    end
  end

  task automatic idle(input bit sof);
    pix_valid_i = 1'b0;
    sof_i = sof;
    pix_i = 8'($urandom);
    @(posedge clk); #1;
    sof_i = 1'b0;
    if (sof) begin mx = 0; my = 0; end
  endtask

  task automatic send(input int base, input bit sof);
    exp_t e;
    int t, m, b;
    if (sof) begin mx = 0; my = 0; end
    b = (base + 16 * my + mx) & 255;
    t = (my >= 2) ? ((base + 16 * (my - 2) + mx) & 255) : 0;
    m = (my >= 1) ? ((base + 16 * (my - 1) + mx) & 255) : 0;
    e.top = t[7:0]; e.mid = m[7:0]; e.bot = b[7:0];
    e.x = mx[1:0]; e.y = my[1:0];
    e.done = (mx == 3 && my == 3);
    if (PAD == 1 || my >= 2) q.push_back(e);
    pix_valid_i = 1'b1;
    sof_i = sof;
    pix_i = b[7:0];
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
    sof_i = 1'b0;
    if (e.done) n_done_exp++;
    if (mx == 3) begin mx = 0; my = (my == 3) ? 0 : my + 1; end
    else mx++;
  endtask

  task automatic burst(input int base, input int n);
    for (int i = 0; i < n; i++) send(base, 1'b0);
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) idle(1'b0);
      send(base, 1'b0);
      if (gaps && i == 5) begin
        idle(1'b0);
        idle(1'b0);
        chk("hold_bot", 32'(bot_o), 32'h11);
        chk("hold_x", 32'(col_x_o), 32'd1);
        chk("hold_valid", 32'(col_valid_o), 32'd0);
      end
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_top"}, 32'(top_o), 32'd0);
    chk({tag, "_mid"}, 32'(mid_o), 32'd0);
    chk({tag, "_bot"}, 32'(bot_o), 32'd0);
    chk({tag, "_x"}, 32'(col_x_o), 32'd0);
    chk({tag, "_y"}, 32'(row_y_o), 32'd0);
    chk({tag, "_valid"}, 32'(col_valid_o), 32'd0);
    chk({tag, "_done"}, 32'(frame_done_o), 32'd0);
  endtask

  initial begin
    int c0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // gap-free frame
    c0 = n_cols;
    frame(0, 1'b0);
    settle();
    chk("cols_frame_gapfree", 32'(n_cols - c0), (PAD == 1) ? 32'd16 : 32'd8);

    // random gaps, same frame content
    c0 = n_cols;
    frame(0, 1'b1);
    settle();
    chk("cols_frame_gaps", 32'(n_cols - c0), (PAD == 1) ? 32'd16 : 32'd8);

    // back-to-back frame with distinct data
    frame(8'h80, 1'b0);

    // sof with no pixel resets position
    burst(0, 5);
    idle(1'b1);
    frame(0, 1'b0);

    // sof with pixel at (2,3) aborts the frame
    burst(0, 14);
    send(0, 1'b1);
    burst(0, 15);
    settle();

    // async reset after pixel (1,2)
    burst(0, 10);
    settle();
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mx = 0; my = 0;
    c0 = n_cols;
    frame(0, 1'b0);
    settle();
    chk("cols_after_reset", 32'(n_cols - c0), (PAD == 1) ? 32'd16 : 32'd8);

    repeat (3) @(posedge clk);
    settle();
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_done_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
